// File: rtl/racetrack_shift_ctrl_pkg.sv
// Shared types and constants for the racetrack shift controller.
package racetrack_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RESET = 2'd3
    } shift_state_t;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    localparam int SHIFT_CYCLES_DEF = 1;

endpackage

// File: rtl/rt_step_timer.sv
// SHIFT_CYCLES prescaler: first_o marks the first cycle of a step period,
// zero_o the last one. With SHIFT_CYCLES=1 both are constant 1.
module rt_step_timer
    import racetrack_shift_ctrl_pkg::*;
#(
    parameter int SHIFT_CYCLES = SHIFT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o,
    output logic first_o
);

    generate
        if (SHIFT_CYCLES == 1) begin : g_bypass
            logic unused_timer_in;
            assign unused_timer_in = ^{clk_i, rst_i, load_i, en_i};
            assign zero_o  = 1'b1;
            assign first_o = 1'b1;
        end else begin : g_count
            localparam int TW = $clog2(SHIFT_CYCLES);
            localparam logic [TW-1:0] RELOAD = TW'(SHIFT_CYCLES - 1);

            logic [TW-1:0] tmr_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    tmr_q <= '0;
                else if (load_i)
                    tmr_q <= RELOAD;
                else if (en_i)
                    tmr_q <= (tmr_q == '0) ? RELOAD : tmr_q - TW'(1);
            end

            assign zero_o  = (tmr_q == '0);
            assign first_o = (tmr_q == RELOAD);
        end
    endgenerate

endmodule

// File: rtl/racetrack_shift_ctrl.sv
// Racetrack shift controller: issues one pulse per domain step, tracks the
// track offset, and replays the set count to return the track home.
module racetrack_shift_ctrl
    import racetrack_shift_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 10,
    parameter int N_POS        = 1024,
    parameter int SHIFT_CYCLES = SHIFT_CYCLES_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 shift_en_s_i,
    input  logic                 shift_en_r_i,
    input  logic                 shift_select_i,
    input  logic                 shift_s_i,
    input  logic                 source_shift_sel_i,
    input  logic [CNT_WIDTH-1:0] shift_n_i,
    output logic                 shift_pulse_o,
    output logic                 shift_dir_o,
    output logic                 shift_done_s_o,
    output logic                 shift_done_r_o,
    output logic [CNT_WIDTH-1:0] pos_o,
    output logic                 err_o
);

    localparam logic [CNT_WIDTH:0]   NPOS_X  = (CNT_WIDTH + 1)'(N_POS);
    localparam logic [CNT_WIDTH-1:0] POS_MAX = CNT_WIDTH'(N_POS - 1);

    shift_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] pos_q, pos_d;
    logic                 err_q, err_d;

    logic                 n_oor;
    logic [CNT_WIDTH-1:0] n_clamped;
    logic                 active, cnt_nz, run, pulse, step;
    logic                 tmr_load, tmr_zero, tmr_first;

    assign n_oor     = ({1'b0, shift_n_i} >= NPOS_X);
    assign n_clamped = n_oor ? POS_MAX : shift_n_i;

    // The pulse opens a step period and the count retires when it closes,
    // so done never rises before the last step period has elapsed.
    assign active = (state_q == ST_SET   && shift_en_s_i) ||
                    (state_q == ST_RESET && shift_en_r_i);
    assign cnt_nz = (cnt_q != '0);
    assign run    = active && shift_select_i && cnt_nz;
    assign pulse  = run && tmr_first;
    assign step   = run && tmr_zero;

    rt_step_timer #(
        .SHIFT_CYCLES(SHIFT_CYCLES)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .en_i   (run),
        .zero_o (tmr_zero),
        .first_o(tmr_first)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (shift_en_s_i) begin
                    state_d  = ST_SET;
                    cnt_d    = n_clamped;
                    n_d      = n_clamped;
                    tmr_load = 1'b1;
                    err_d    = err_q | n_oor;
                end else if (shift_en_r_i) begin
                    state_d  = ST_RESET;
                    cnt_d    = source_shift_sel_i ? n_q : n_clamped;
                    tmr_load = 1'b1;
                    err_d    = err_q | (n_oor & ~source_shift_sel_i);
                end
            end
            ST_SET: begin
                if (!cnt_nz)
                    state_d = ST_HOLD;
                else if (step)
                    cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            ST_HOLD: begin
                if (shift_en_r_i) begin
                    state_d  = ST_RESET;
                    cnt_d    = source_shift_sel_i ? n_q : n_clamped;
                    tmr_load = 1'b1;
                    err_d    = err_q | (n_oor & ~source_shift_sel_i);
                end
            end
            ST_RESET: begin
                if (!cnt_nz) begin
                    state_d = ST_IDLE;
                    n_d     = '0;
                end else if (step) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pos_d = pos_q;
        if (pulse) begin
            if (shift_dir_o == SHIFT_LEFT)
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + CNT_WIDTH'(1);
            else
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - CNT_WIDTH'(1);
        end
    end

    assign shift_pulse_o  = pulse;
    assign shift_dir_o    = (state_q == ST_SET) ? SHIFT_LEFT : SHIFT_RIGHT;
    assign shift_done_s_o = (state_q == ST_SET)   && !cnt_nz;
    assign shift_done_r_o = (state_q == ST_RESET) && !cnt_nz;
    assign pos_o          = pos_q;
    assign err_o          = err_q;

    a_dir_match: assert property (@(posedge clk_i) disable iff (rst_i)
        shift_pulse_o |-> (shift_s_i == shift_dir_o));

    a_done_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        !(shift_done_s_o && shift_done_r_o));

endmodule

// File: tb/tb_racetrack_shift_ctrl.sv
// Directed bench: default instance, SHIFT_CYCLES=3 instance, N_POS=16 instance.
module tb_racetrack_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en_s, en_r;
    logic       sel, s, src;
    logic [9:0] n;

    logic       pulse [3];
    logic       dir   [3];
    logic       dns   [3];
    logic       dnr   [3];
    logic       err   [3];
    logic [9:0] pos   [3];

    int n_assert = 0;
    int n_fail   = 0;
    int np;

    always #5 clk = ~clk;

    racetrack_shift_ctrl u_d0 (
        .clk_i(clk), .rst_i(rst), .shift_en_s_i(en_s[0]), .shift_en_r_i(en_r[0]),
        .shift_select_i(sel), .shift_s_i(s), .source_shift_sel_i(src), .shift_n_i(n),
        .shift_pulse_o(pulse[0]), .shift_dir_o(dir[0]), .shift_done_s_o(dns[0]),
        .shift_done_r_o(dnr[0]), .pos_o(pos[0]), .err_o(err[0]));

    racetrack_shift_ctrl #(.SHIFT_CYCLES(3)) u_d1 (
        .clk_i(clk), .rst_i(rst), .shift_en_s_i(en_s[1]), .shift_en_r_i(en_r[1]),
        .shift_select_i(sel), .shift_s_i(s), .source_shift_sel_i(src), .shift_n_i(n),
        .shift_pulse_o(pulse[1]), .shift_dir_o(dir[1]), .shift_done_s_o(dns[1]),
        .shift_done_r_o(dnr[1]), .pos_o(pos[1]), .err_o(err[1]));

    racetrack_shift_ctrl #(.N_POS(16)) u_d2 (
        .clk_i(clk), .rst_i(rst), .shift_en_s_i(en_s[2]), .shift_en_r_i(en_r[2]),
        .shift_select_i(sel), .shift_s_i(s), .source_shift_sel_i(src), .shift_n_i(n),
        .shift_pulse_o(pulse[2]), .shift_dir_o(dir[2]), .shift_done_s_o(dns[2]),
        .shift_done_r_o(dnr[2]), .pos_o(pos[2]), .err_o(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en_s = '0;
        en_r = '0;
        #1;
        rst  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en_s = '0; en_r = '0; sel = 1'b0; s = 1'b0; src = 1'b0; n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse",  32'(pulse[0]), 32'(0));
        check("rst_dir",    32'(dir[0]),   32'(0));
        check("rst_done_s", 32'(dns[0]),   32'(0));
        check("rst_done_r", 32'(dnr[0]),   32'(0));
        check("rst_pos",    32'(pos[0]),   32'(0));
        check("rst_err",    32'(err[0]),   32'(0));
        rst = 1'b0;

        // round trip N=5
        tick(); n = 10'd5; s = 1'b1; sel = 1'b1; src = 1'b1; en_s[0] = 1'b1; #1;
        check("rt_c0_pulse", 32'(pulse[0]), 32'(0));
        for (int c = 1; c <= 6; c++) begin
            tick(); #1;
            check("rt_set_pulse",  32'(pulse[0]), 32'(c <= 5));
            check("rt_set_dir",    32'(dir[0]),   32'(1));
            check("rt_set_done_s", 32'(dns[0]),   32'(c == 6));
        end
        check("rt_set_pos", 32'(pos[0]), 32'(5));
        tick(); en_s[0] = 1'b0; en_r[0] = 1'b1; s = 1'b0; #1;
        check("rt_hold_done_s", 32'(dns[0]), 32'(0));
        check("rt_hold_pos",    32'(pos[0]), 32'(5));
        for (int r = 1; r <= 6; r++) begin
            tick(); #1;
            check("rt_rst_pulse",  32'(pulse[0]), 32'(r <= 5));
            check("rt_rst_dir",    32'(dir[0]),   32'(0));
            check("rt_rst_done_r", 32'(dnr[0]),   32'(r == 6));
        end
        check("rt_rst_pos", 32'(pos[0]), 32'(0));

        // back-to-back set with N=3
        tick(); en_r[0] = 1'b0; en_s[0] = 1'b1; n = 10'd3; s = 1'b1; #1;
        check("b2b_c0_pulse",  32'(pulse[0]), 32'(0));
        check("b2b_c0_done_r", 32'(dnr[0]),   32'(0));
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            check("b2b_pulse",  32'(pulse[0]), 32'(c <= 3));
            check("b2b_done_s", 32'(dns[0]),   32'(c == 4));
        end
        check("b2b_pos", 32'(pos[0]), 32'(3));
        tick(); en_s[0] = 1'b0;
        do_reset();

        // zero count with both enables high: set wins
        tick(); n = 10'd0; s = 1'b1; en_s[0] = 1'b1; en_r[0] = 1'b1;
        tick(); #1;
        check("zero_pulse",  32'(pulse[0]), 32'(0));
        check("zero_done_s", 32'(dns[0]),   32'(1));
        check("zero_done_r", 32'(dnr[0]),   32'(0));
        tick(); en_s[0] = 1'b0; en_r[0] = 1'b0; #1;
        check("zero_hold_done_s", 32'(dns[0]), 32'(0));
        do_reset();

        // reset-shift from IDLE with latched source and no prior set
        tick(); src = 1'b1; n = 10'd7; s = 1'b0; en_r[0] = 1'b1;
        tick(); #1;
        check("nq0_pulse",  32'(pulse[0]), 32'(0));
        check("nq0_done_r", 32'(dnr[0]),   32'(1));
        check("nq0_pos",    32'(pos[0]),   32'(0));
        tick(); en_r[0] = 1'b0;

        // async reset during the 3rd pulse of N=8
        do_reset();
        tick(); n = 10'd8; s = 1'b1; en_s[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            check("arst_pulse", 32'(pulse[0]), 32'(1));
        end
        check("arst_pos_pre", 32'(pos[0]), 32'(2));
        rst = 1'b1; en_s[0] = 1'b0; #1;
        check("arst_pulse_0", 32'(pulse[0]), 32'(0));
        check("arst_dir_0",   32'(dir[0]),   32'(0));
        check("arst_pos_0",   32'(pos[0]),   32'(0));
        check("arst_done_0",  32'(dns[0]),   32'(0));
        rst = 1'b0;
        tick(); n = 10'd2; en_s[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            check("arst_new_pulse",  32'(pulse[0]), 32'(c <= 2));
            check("arst_new_done_s", 32'(dns[0]),   32'(c == 3));
        end
        check("arst_new_pos", 32'(pos[0]), 32'(2));
        tick(); en_s[0] = 1'b0;
        do_reset();

        // SHIFT_CYCLES=3, N=2, select low in cycles 2 and 3
        tick(); n = 10'd2; s = 1'b1; sel = 1'b1; en_s[1] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick(); sel = !(c == 2 || c == 3); #1;
            check("sc3_pulse",  32'(pulse[1]), 32'(c == 1 || c == 6));
            check("sc3_done_s", 32'(dns[1]),   32'(c == 9));
        end
        check("sc3_pos", 32'(pos[1]), 32'(2));
        tick(); en_s[1] = 1'b0; sel = 1'b1;
        do_reset();

        // N_POS=16: count 20 clamps to 15, err sticky
        tick(); n = 10'd20; s = 1'b1; en_s[2] = 1'b1; #1;
        check("oor_err_pre", 32'(err[2]), 32'(0));
        np = 0;
        for (int c = 1; c <= 16; c++) begin
            tick(); #1;
            np = np + int'(pulse[2]);
            if (c == 1) check("oor_err_set", 32'(err[2]), 32'(1));
            check("oor_done_s", 32'(dns[2]), 32'(c == 16));
        end
        check("oor_pulses", 32'(np), 32'(15));
        check("oor_pos",    32'(pos[2]), 32'(15));
        tick(); en_s[2] = 1'b0; #1;
        check("oor_err_sticky", 32'(err[2]), 32'(1));
        do_reset(); #1;
        check("oor_err_cleared", 32'(err[2]), 32'(0));

        // wrap: one right step from position 0
        tick(); n = 10'd1; src = 1'b0; s = 1'b0; en_r[2] = 1'b1;
        tick(); #1;
        check("wrap_pulse", 32'(pulse[2]), 32'(1));
        check("wrap_dir",   32'(dir[2]),   32'(0));
        tick(); #1;
        check("wrap_pos",    32'(pos[2]), 32'(15));
        check("wrap_done_r", 32'(dnr[2]), 32'(1));
        check("wrap_err",    32'(err[2]), 32'(0));
        tick(); en_r[2] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
